fetch_sequencer: RTL and testbench

//  Instruction fetch/issue controller placed in front of the cpu core. Runs a

---
 rtl/fetch_sequencer_if.sv | 23 ++
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Memory read bus and instruction issue bus between the fetch sequencer and its
// neighbours. The sequencer is the master; the memory/core side is the slave.
interface fetch_sequencer_if #(
    parameter int N      = 16,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_valid;
    logic [N-1:0]      mem_data;
    logic [N-1:0]      inst;
    logic              inst_valid;

    modport master (
        output mem_addr, mem_rd, inst, inst_valid,
        input  mem_valid, mem_data
    );

    modport slave (
        input  mem_addr, mem_rd, inst, inst_valid,
        output mem_valid, mem_data
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue controller: walks pc over program memory, issues each
// word as a one-cycle strobe, stops on HALT. Define FETCH_STEP_EN for single-step mode.
module fetch_sequencer #(
    parameter int             N       = 16,
    parameter int             ADDR_W  = 8,
    parameter int             OPW     = 4,
    parameter logic [OPW-1:0] HALT_OP = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef FETCH_STEP_EN
    input  logic              step,
`endif
    fetch_sequencer_if.master bus,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

`ifdef FETCH_STEP_EN
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, HALT, PAUSE} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;
`endif

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc_next;
    logic [N-1:0]      inst_next;
    logic [OPW-1:0]    opcode;
    logic              word_ready;

    assign bus.mem_addr = pc;
    assign opcode       = bus.mem_data[N-1 -: OPW];
    assign word_ready   = bus.mem_rd && bus.mem_valid;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        inst_next  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    pc_next    = '0;
                end
            end
            FETCH: begin
                // A HALT word leaves pc pointing at itself and is never issued.
                if (word_ready) begin
                    if (opcode == HALT_OP) begin
                        state_next = HALT;
                    end else begin
                        state_next = ISSUE;
                        inst_next  = bus.mem_data;
                        pc_next    = pc + 1'b1;
                    end
                end
            end
            ISSUE: begin
`ifdef FETCH_STEP_EN
                state_next = PAUSE;
`else
                state_next = FETCH;
`endif
            end
`ifdef FETCH_STEP_EN
            PAUSE: begin
                if (step) begin
                    state_next = FETCH;
                end
            end
`endif
            HALT: begin
                if (start) begin
                    state_next = FETCH;
                    pc_next    = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All outputs are registered from the next state, so inst is non-zero only
    // in the cycle that carries inst_valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            pc             <= '0;
            bus.mem_rd     <= 1'b0;
            bus.inst       <= '0;
            bus.inst_valid <= 1'b0;
            busy           <= 1'b0;
            halted         <= 1'b0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            bus.mem_rd     <= (state_next == FETCH);
            bus.inst       <= inst_next;
            bus.inst_valid <= (state_next == ISSUE);
`ifdef FETCH_STEP_EN
            busy           <= (state_next == FETCH) || (state_next == ISSUE) || (state_next == PAUSE);
`else
            busy           <= (state_next == FETCH) || (state_next == ISSUE);
`endif
            halted         <= (state_next == HALT);
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: an 8-bit-pc instance with a latency-programmable
// memory and a tiny cpu model, plus a 2-bit-pc instance for pc wrap.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic start_w;
    logic force_valid;
    int   lat;
    int   wait_cnt = 0;
    int   cyc = 0;
    int   strobes = 0;
    int   checks = 0;
    int   fails = 0;
    int   base_cyc;
    int   base_strobes;

    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic [1:0]  pc_w;
    logic        busy_w;
    logic        halted_w;
    logic [15:0] mem [256];
    logic [15:0] memw [4];
    logic [7:0]  ax = 8'd0;
    logic [7:0]  cpu_out = 8'd0;

`ifdef FETCH_STEP_EN
    logic step;
    logic step_w;
    localparam int GAP = 3;
    logic [15:0] step_prog [3];
`else
    localparam int GAP = 2;
`endif

    fetch_sequencer_if #(.N(16), .ADDR_W(8)) bus ();
    fetch_sequencer_if #(.N(16), .ADDR_W(2)) bus_w ();

    fetch_sequencer #(.N(16), .ADDR_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef FETCH_STEP_EN
        .step(step),
`endif
        .bus(bus),
        .pc(pc),
        .busy(busy),
        .halted(halted)
    );

    fetch_sequencer #(.N(16), .ADDR_W(2)) dut_w (
        .clk(clk),
        .rst(rst),
        .start(start_w),
`ifdef FETCH_STEP_EN
        .step(step_w),
`endif
        .bus(bus_w),
        .pc(pc_w),
        .busy(busy_w),
        .halted(halted_w)
    );

    always #5 clk = ~clk;

    // Memory answers after lat waiting cycles; force_valid injects stray valids.
    assign bus.mem_data    = mem[bus.mem_addr];
    assign bus.mem_valid   = force_valid | (bus.mem_rd && (wait_cnt >= lat));
    assign bus_w.mem_data  = memw[bus_w.mem_addr];
    assign bus_w.mem_valid = bus_w.mem_rd;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_rd && !bus.mem_valid) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (bus.inst_valid) strobes <= strobes + 1;
        if (bus.inst_valid) begin
            case (bus.inst[15:12])
                4'h1:    ax <= bus.inst[7:0];
                4'h2:    cpu_out <= ax;
                4'h3:    ax <= ax + bus.inst[7:0];
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // NOP must be on inst whenever no strobe is present.
    always @(negedge clk) begin
        if (!bus.inst_valid) checkOutput("nop_inst", 32'(bus.inst), 32'd0);
        if (!bus_w.inst_valid) checkOutput("nop_inst_w", 32'(bus_w.inst), 32'd0);
    end

    function automatic logic cond(input int which);
        case (which)
            0:       return bus.inst_valid;
            1:       return bus.mem_rd;
            2:       return bus_w.mem_rd;
            3:       return bus_w.inst_valid;
            4:       return halted;
            default: return 1'b1;
        endcase
    endfunction

    task automatic waitFor(input int which, input string tag);
        int n = 0;
        while (!cond(which) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_timeout"}, 32'(cond(which)), 32'd1);
    endtask

    task automatic applyStimulus(input logic go, input logic go_w);
        start   = go;
        start_w = go_w;
        @(negedge clk);
        start   = 1'b0;
        start_w = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        start_w = 1'b0;
        force_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h102A;
        mem[1] = 16'h2000;
        mem[2] = 16'hF000;
        memw[0] = 16'h1001;
        memw[1] = 16'h1002;
        memw[2] = 16'h1003;
        memw[3] = 16'h1004;
`ifdef FETCH_STEP_EN
        step = 1'b1;
        step_w = 1'b1;
`endif

        $display("[TB] reset");
        repeat (2) @(negedge clk);
        checkOutput("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        checkOutput("rst_inst", 32'(bus.inst), 32'd0);
        checkOutput("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        $display("[TB] program with zero-latency memory");
        base_cyc = cyc;
        base_strobes = strobes;
        applyStimulus(1'b1, 1'b0);
        checkOutput("t2_fetch_rd", 32'(bus.mem_rd), 32'd1);
        checkOutput("t2_fetch_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("t2_fetch_busy", 32'(busy), 32'd1);
        waitFor(0, "t2_s1");
        checkOutput("t2_s1_cycle", 32'(cyc - base_cyc), 32'd2);
        checkOutput("t2_s1_inst", 32'(bus.inst), 32'h102A);
        checkOutput("t2_s1_pc", 32'(pc), 32'd1);
        checkOutput("t2_s1_rd", 32'(bus.mem_rd), 32'd0);
        @(negedge clk);
        waitFor(0, "t2_s2");
        checkOutput("t2_s2_cycle", 32'(cyc - base_cyc), 32'(2 + GAP));
        checkOutput("t2_s2_inst", 32'(bus.inst), 32'h2000);
        checkOutput("t2_s2_pc", 32'(pc), 32'd2);
        waitFor(4, "t2_halt");
        checkOutput("t2_halt_cycle", 32'(cyc - base_cyc), 32'(2 + 2 * GAP));
        checkOutput("t2_halt_pc", 32'(pc), 32'd2);
        checkOutput("t2_halt_busy", 32'(busy), 32'd0);
        checkOutput("t2_halt_rd", 32'(bus.mem_rd), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("t2_still_halted", 32'(halted), 32'd1);
        checkOutput("t2_strobes", 32'(strobes - base_strobes), 32'd2);
        checkOutput("t2_cpu_out", 32'(cpu_out), 32'd42);

        $display("[TB] program with 3-cycle memory latency");
        lat = 3;
        mem[0] = 16'h1033;
        base_strobes = strobes;
        applyStimulus(1'b1, 1'b0);
        checkOutput("t3_halt_cleared", 32'(halted), 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t3_wait_rd", 32'(bus.mem_rd), 32'd1);
            checkOutput("t3_wait_no_strobe", 32'(bus.inst_valid), 32'd0);
            @(negedge clk);
        end
        checkOutput("t3_valid_rd", 32'(bus.mem_rd), 32'd1);
        waitFor(0, "t3_s1");
        checkOutput("t3_s1_inst", 32'(bus.inst), 32'h1033);
        @(negedge clk);
        waitFor(0, "t3_s2");
        checkOutput("t3_s2_inst", 32'(bus.inst), 32'h2000);
        waitFor(4, "t3_halt");
        checkOutput("t3_halt_pc", 32'(pc), 32'd2);
        @(negedge clk);
        checkOutput("t3_strobes", 32'(strobes - base_strobes), 32'd2);
        checkOutput("t3_cpu_out", 32'(cpu_out), 32'd51);

        $display("[TB] reset during fetch wait");
        applyStimulus(1'b1, 1'b0);
        waitFor(0, "t4_s1");
        checkOutput("t4_s1_pc", 32'(pc), 32'd1);
        waitFor(1, "t4_fetch");
        @(negedge clk);
        checkOutput("t4_mid_rd", 32'(bus.mem_rd), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t4_rst_rd", 32'(bus.mem_rd), 32'd0);
        checkOutput("t4_rst_pc", 32'(pc), 32'd0);
        checkOutput("t4_rst_busy", 32'(busy), 32'd0);
        checkOutput("t4_rst_valid", 32'(bus.inst_valid), 32'd0);
        rst = 1'b1;
        force_valid = 1'b1;
        base_strobes = strobes;
        repeat (2) @(negedge clk);
        force_valid = 1'b0;
        @(negedge clk);
        checkOutput("t4_late_strobes", 32'(strobes - base_strobes), 32'd0);
        checkOutput("t4_late_busy", 32'(busy), 32'd0);
        checkOutput("t4_late_rd", 32'(bus.mem_rd), 32'd0);
        checkOutput("t4_late_pc", 32'(pc), 32'd0);

        $display("[TB] 2-bit pc wrap");
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            waitFor(2, "t5_fetch");
            checkOutput("t5_addr", 32'(bus_w.mem_addr), 32'(i % 4));
            waitFor(3, "t5_strobe");
            checkOutput("t5_inst", 32'(bus_w.inst), 32'(memw[i % 4]));
            checkOutput("t5_pc", 32'(pc_w), 32'((i + 1) % 4));
            checkOutput("t5_busy", 32'(busy_w), 32'd1);
        end
        checkOutput("t5_not_halted", 32'(halted_w), 32'd0);

`ifdef FETCH_STEP_EN
        $display("[TB] single-step program");
        step = 1'b0;
        mem[0] = 16'h1005;
        mem[1] = 16'h1007;
        mem[2] = 16'h3003;
        mem[3] = 16'h2000;
        mem[4] = 16'hF000;
        step_prog[0] = 16'h1007;
        step_prog[1] = 16'h3003;
        step_prog[2] = 16'h2000;
        base_strobes = strobes;
        applyStimulus(1'b1, 1'b0);
        waitFor(0, "t6_s0");
        checkOutput("t6_s0_inst", 32'(bus.inst), 32'h1005);
        @(negedge clk);
        checkOutput("t6_pause_busy", 32'(busy), 32'd1);
        checkOutput("t6_pause_rd", 32'(bus.mem_rd), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("t6_pause_strobes", 32'(strobes - base_strobes), 32'd1);
        for (int k = 0; k < 4; k++) begin
            base_strobes = strobes;
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            if (k == 0) begin
                step = 1'b1;
                @(negedge clk);
                step = 1'b0;
                checkOutput("t6_step_in_fetch_rd", 32'(bus.mem_rd), 32'd1);
            end
            if (k < 3) begin
                waitFor(0, "t6_step");
                checkOutput("t6_step_inst", 32'(bus.inst), 32'(step_prog[k]));
                repeat (4) @(negedge clk);
                checkOutput("t6_step_strobes", 32'(strobes - base_strobes), 32'd1);
                checkOutput("t6_step_busy", 32'(busy), 32'd1);
                checkOutput("t6_step_rd", 32'(bus.mem_rd), 32'd0);
            end else begin
                waitFor(4, "t6_halt");
                @(negedge clk);
                checkOutput("t6_halt_strobes", 32'(strobes - base_strobes), 32'd0);
                checkOutput("t6_halt_pc", 32'(pc), 32'd4);
                checkOutput("t6_halted", 32'(halted), 32'd1);
            end
        end
        checkOutput("t6_cpu_out", 32'(cpu_out), 32'd10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
